// File: rtl/dds_period_meter.sv
// dds_period_meter
//   Measures the period of a signed 8-bit DDS waveform. The period is the
//   number of valid samples between successive negative-to-positive
//   crossings. ARM waits for the first crossing after a restart. MEASURE
//   counts valid samples and reports cnt+1 on every following crossing.
//   A counter that reaches 16'hFFFF without a crossing raises a timeout
//   strobe and drops back to ARM.
//
//   Optional feature, enabled by defining PERIOD_AVG_EN:
//     period becomes the floor average of the last four measured periods.
//     period_valid and locked first assert on the 4th measurement after ARM
//     entry, then on every measurement after that (sliding window).
//   The default build (macro undefined) reports each period directly and
//   contains no averaging logic.
module dds_period_meter (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SET,
  input  logic              sample_valid,
  input  logic signed [7:0] sample_in,
  output logic [15:0]       period,
  output logic              period_valid,
  output logic              timeout,
  output logic              locked
);

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        prev_neg;

  // Only the sign bit matters for crossing detection.
  logic        sample_neg;
  logic        unused_mag;
  assign sample_neg = sample_in[7];
  assign unused_mag = ^sample_in[6:0];

  // Rising crossing: the previous valid sample was negative and this one is not.
  logic        crossing;
  assign crossing = sample_valid & prev_neg & ~sample_neg;

  // Period candidate. The crossing sample itself counts as one more sample.
  logic [15:0] meas;
  assign meas = cnt + 16'd1;

  logic        cnt_max;
  assign cnt_max = &cnt;

`ifdef PERIOD_AVG_EN
  // Window of the last four measurements, newest in slot 0. Empty slots hold
  // zero, so the running sum stays exact while the window fills.
  logic [3:0][15:0] avg_hist;
  logic [17:0]      avg_sum;
  logic [2:0]       avg_fill;
  logic [17:0]      avg_sum_next;

  // Running sum: drop the oldest entry and add the new measurement.
  assign avg_sum_next = avg_sum - {2'b00, avg_hist[3]} + {2'b00, meas};
`endif

  // Measurement state machine with registered strobes and outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ARM;
      cnt          <= 16'd0;
      prev_neg     <= 1'b0;
      period       <= 16'd0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      locked       <= 1'b0;
`ifdef PERIOD_AVG_EN
      avg_hist     <= '0;
      avg_sum      <= 18'd0;
      avg_fill     <= 3'd0;
`endif
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (SET) begin
        // Restart after a DDS step change. The last reported period is kept
        // so downstream logic still sees a value until a new one arrives.
        state    <= ARM;
        cnt      <= 16'd0;
        prev_neg <= 1'b0;
        locked   <= 1'b0;
`ifdef PERIOD_AVG_EN
        avg_hist <= '0;
        avg_sum  <= 18'd0;
        avg_fill <= 3'd0;
`endif
      end else if (sample_valid) begin
        prev_neg <= sample_neg;
        unique case (state)
          ARM: begin
            // The first crossing only defines the starting phase.
            if (crossing) begin
              cnt   <= 16'd0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (crossing) begin
              cnt <= 16'd0;
`ifdef PERIOD_AVG_EN
              avg_hist <= {avg_hist[2:0], meas};
              avg_sum  <= avg_sum_next;
              if (avg_fill != 3'd4)
                avg_fill <= avg_fill + 3'd1;
              // Report only once the window holds four real measurements.
              if (avg_fill >= 3'd3) begin
                period       <= avg_sum_next[17:2];
                period_valid <= 1'b1;
                locked       <= 1'b1;
              end
`else
              period       <= meas;
              period_valid <= 1'b1;
              locked       <= 1'b1;
`endif
            end else if (cnt_max) begin
              // No crossing within the counter range: the input has stalled.
              timeout <= 1'b1;
              cnt     <= 16'd0;
              locked  <= 1'b0;
              state   <= ARM;
`ifdef PERIOD_AVG_EN
              avg_hist <= '0;
              avg_sum  <= 18'd0;
              avg_fill <= 3'd0;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_period_meter.sv
// Directed bench for dds_period_meter (default build).
module tb_dds_period_meter;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              SET;
  logic              sample_valid;
  logic signed [7:0] sample_in;
  logic [15:0]       period;
  logic              period_valid;
  logic              timeout;
  logic              locked;

  int checks = 0;
  int errors = 0;

  int       strobes[$];
  logic [1:0] set_snap;

  dds_period_meter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SET          (SET),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
    .locked       (locked)
  );

  always #5 CLK = ~CLK;

  // Sign-accurate 256-entry sine model: zero at 0 and 128, positive in
  // 1..127, negative in 129..255.
  function automatic logic signed [7:0] dds(input int p);
    int q;
    int v;
    q = p & 255;
    if (q == 0 || q == 128) v = 0;
    else if (q < 128)       v = q / 2 + 1;
    else                    v = -((q - 128) / 2) - 1;
    return 8'(v);
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic feed(input logic signed [7:0] s);
    sample_valid = 1'b1;
    sample_in    = s;
    SET          = 1'b0;
    cyc();
  endtask

  task automatic do_set();
    SET          = 1'b1;
    sample_valid = 1'b0;
    cyc();
    SET          = 1'b0;
  endtask

  // Stream a DDS with given start phase and step; toggle=1 makes every odd
  // cycle invalid (with a negative garbage sample). Records strobe cycles.
  task automatic run_dds(input int start, input int step, input bit toggle,
                         input int n, input int set_at);
    int  ph;
    bit  v;
    ph = start;
    strobes.delete();
    set_snap = 2'b11;
    for (int i = 0; i < n; i++) begin
      v            = toggle ? (i % 2 == 0) : 1'b1;
      sample_valid = v;
      sample_in    = v ? dds(ph) : -8'sd50;
      SET          = (i == set_at);
      cyc();
      if (period_valid) strobes.push_back(i);
      if (i == set_at) set_snap = {period_valid, locked};
      if (v) ph += step;
    end
    sample_valid = 1'b0;
    SET          = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; SET = 1'b1; sample_valid = 1'b1; sample_in = 8'sd5;
    cyc(); cyc();
    RESET = 1'b0; SET = 1'b0; sample_valid = 1'b0;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b want 0", period_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
  endtask

  task automatic test_step1();
    run_dds(129, 1, 1'b0, 700, -1);
    checks++; if (strobes.size() !== 2) begin errors++; $display("FAIL s1_count got %0d want 2", strobes.size()); end
    checks++; if (strobes.size() < 1 || strobes[0] !== 383) begin errors++; $display("FAIL s1_first got %0d want 383", strobes.size() ? strobes[0] : -1); end
    checks++; if (strobes.size() < 2 || strobes[1] - strobes[0] !== 256) begin errors++; $display("FAIL s1_interval got %0d want 256", strobes.size() > 1 ? strobes[1] - strobes[0] : -1); end
    checks++; if (period !== 16'd256) begin errors++; $display("FAIL s1_period got %0d want 256", period); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL s1_locked got %b want 1", locked); end
  endtask

  task automatic test_step4_toggle();
    do_set();
    checks++; if (period !== 16'd256) begin errors++; $display("FAIL set_hold_period got %0d want 256", period); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL set_locked got %b want 0", locked); end
    run_dds(132, 4, 1'b1, 340, -1);
    checks++; if (strobes.size() !== 2) begin errors++; $display("FAIL s4_count got %0d want 2", strobes.size()); end
    checks++; if (strobes.size() < 1 || strobes[0] !== 190) begin errors++; $display("FAIL s4_first got %0d want 190", strobes.size() ? strobes[0] : -1); end
    checks++; if (strobes.size() < 2 || strobes[1] - strobes[0] !== 128) begin errors++; $display("FAIL s4_interval got %0d want 128", strobes.size() > 1 ? strobes[1] - strobes[0] : -1); end
    checks++; if (period !== 16'd64) begin errors++; $display("FAIL s4_period got %0d want 64", period); end
  endtask

  task automatic test_set_crossing();
    do_set();
    run_dds(136, 8, 1'b0, 160, 79);
    checks++; if (set_snap !== 2'b00) begin errors++; $display("FAIL setx_snap got %b want 00", set_snap); end
    checks++; if (strobes.size() !== 2) begin errors++; $display("FAIL setx_count got %0d want 2", strobes.size()); end
    checks++; if (strobes.size() < 2 || strobes[0] !== 47 || strobes[1] !== 143) begin errors++; $display("FAIL setx_times got %0d/%0d want 47/143", strobes.size() > 0 ? strobes[0] : -1, strobes.size() > 1 ? strobes[1] : -1); end
    checks++; if (period !== 16'd32 || locked !== 1'b1) begin errors++; $display("FAIL setx_final got %0d/%b want 32/1", period, locked); end
  endtask

  task automatic test_timeout();
    int early;
    do_set();
    feed(-8'sd5); feed(8'sd5); feed(-8'sd5); feed(8'sd5);
    checks++; if (period_valid !== 1'b1 || period !== 16'd2 || locked !== 1'b1) begin errors++; $display("FAIL to_setup got %b/%0d/%b want 1/2/1", period_valid, period, locked); end
    early = 0;
    for (int i = 0; i < 65535; i++) begin
      feed(8'sd5);
      if (timeout) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early got %0d want 0", early); end
    feed(8'sd5);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_strobe got %b want 1", timeout); end
    checks++; if (period !== 16'd2 || locked !== 1'b0 || period_valid !== 1'b0) begin errors++; $display("FAIL to_outputs got %0d/%b/%b want 2/0/0", period, locked, period_valid); end
    feed(8'sd5);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle got %b want 0", timeout); end
    feed(-8'sd5); feed(8'sd5);
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL to_arm got %b want 0", period_valid); end
    feed(-8'sd5); feed(8'sd5);
    checks++; if (period_valid !== 1'b1 || period !== 16'd2) begin errors++; $display("FAIL to_remeasure got %b/%0d want 1/2", period_valid, period); end
  endtask

  task automatic test_reset_mid();
    do_set();
    run_dds(129, 1, 1'b0, 228, -1);
    RESET = 1'b1; sample_valid = 1'b1; sample_in = 8'sd5; SET = 1'b1;
    cyc();
    RESET = 1'b0; SET = 1'b0; sample_valid = 1'b0;
    checks++; if ({period, period_valid, timeout, locked} !== 19'd0) begin errors++; $display("FAIL rmid_outputs got %0d/%b/%b/%b want 0/0/0/0", period, period_valid, timeout, locked); end
    feed(8'sd5); feed(8'sd5); feed(8'sd5);
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_cross got %b want 0", period_valid); end
    feed(-8'sd5); feed(8'sd5);
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL rmid_arm got %b want 0", period_valid); end
    feed(-8'sd5); feed(8'sd5);
    checks++; if (period_valid !== 1'b1 || period !== 16'd2 || locked !== 1'b1) begin errors++; $display("FAIL rmid_measure got %b/%0d/%b want 1/2/1", period_valid, period, locked); end
  endtask

  initial begin
    RESET = 1'b1; SET = 1'b0; sample_valid = 1'b0; sample_in = 8'sd0;
    test_reset();
    test_step1();
    test_step4_toggle();
    test_set_crossing();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
